// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared types for the execute-stage ALU and multiply/divide unit
package mul_div_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } mdu_state_t;

  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// rtl/mul_div_unit_iter_core.sv - shared shift-add / shift-subtract iteration datapath (divider path under MDU_DIV_EN)
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            mode_div,
  input  logic [XLEN-1:0] load_a,
  input  logic [XLEN-1:0] load_b,
  output logic [XLEN-1:0] acc_hi,
  output logic [XLEN-1:0] acc_lo,
  output logic            last
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [XLEN-1:0] hi_q, lo_q, opd_q;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   add_a, add_b, sum, ext;
  logic            add_cin;

  // one adder: hi + multiplicand for multiply, {rem,next bit} - divisor for divide
  always_comb begin
    add_a   = {1'b0, hi_q};
    add_b   = {1'b0, opd_q};
    add_cin = 1'b0;
`ifdef MDU_DIV_EN
    if (mode_div) begin
      add_a   = {hi_q, lo_q[XLEN-1]};
      add_b   = ~{1'b0, opd_q};
      add_cin = 1'b1;
    end
`endif
    sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};
  end

`ifndef MDU_DIV_EN
  logic unused_mode_div;
  assign unused_mode_div = mode_div;
`endif

  // next value of the 2*XLEN register for one iteration
  always_comb begin
    ext  = lo_q[0] ? sum : {1'b0, hi_q};
    hi_d = ext[XLEN:1];
    lo_d = {ext[0], lo_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
    if (mode_div) begin
      if (!sum[XLEN]) begin
        hi_d = sum[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  // load on start, iterate and count down on step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= load_a;
      opd_q <= load_b;
      cnt_q <= CNT_INIT;
    end else if (step) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;
  assign last   = (cnt_q == '0);

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M/RV64M multiply/divide unit (divide ops enabled by MDU_DIV_EN)
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdu_op_t         in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_err
);

  mdu_state_t      state_q, state_d;
  mdu_op_t         op_q;
  logic            neg_q, special_q, err_q;
  logic [XLEN-1:0] result_q;

  logic            core_start, core_step, core_last;
  logic [XLEN-1:0] acc_hi, acc_lo;

  logic            sign_a, sign_b, neg_d;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            special, special_err;
  logic [XLEN-1:0] special_result, fixed_result;

  // operand magnitudes and result sign; remainder sign follows the dividend
  always_comb begin
    sign_a = ((in_op == MDU_MULH) || (in_op == MDU_MULHSU) ||
              (in_op == MDU_DIV) || (in_op == MDU_REM)) && in_a[XLEN-1];
    sign_b = ((in_op == MDU_MULH) || (in_op == MDU_DIV) || (in_op == MDU_REM)) && in_b[XLEN-1];
    mag_a  = sign_a ? -in_a : in_a;
    mag_b  = sign_b ? -in_b : in_b;
    neg_d  = (in_op == MDU_REM) ? sign_a : (sign_a ^ sign_b);
  end

`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // divide by zero and signed overflow bypass the iterations
  always_comb begin
    special        = 1'b0;
    special_err    = 1'b0;
    special_result = '0;
    if (mdu_is_div(in_op)) begin
      if (in_b == '0) begin
        special        = 1'b1;
        special_result = ((in_op == MDU_DIV) || (in_op == MDU_DIVU)) ? '1 : in_a;
      end else if (((in_op == MDU_DIV) || (in_op == MDU_REM)) &&
                   (in_a == MOST_NEG) && (in_b == '1)) begin
        special        = 1'b1;
        special_result = (in_op == MDU_DIV) ? in_a : '0;
      end
    end
  end
`else
  // without the divider every divide op is answered at once as unsupported
  always_comb begin
    special        = mdu_is_div(in_op);
    special_err    = 1'b1;
    special_result = '0;
  end
`endif

  // final negation and result select from the iteration register
  always_comb begin
    fixed_result = acc_lo;
    case (op_q)
      MDU_MUL, MDU_DIV, MDU_DIVU: fixed_result = neg_q ? -acc_lo : acc_lo;
      MDU_MULH, MDU_MULHSU, MDU_MULHU:
        fixed_result = neg_q ? (~acc_hi + {{(XLEN-1){1'b0}}, (acc_lo == '0)}) : acc_hi;
      MDU_REM, MDU_REMU:          fixed_result = neg_q ? -acc_hi : acc_hi;
      default:                    fixed_result = acc_lo;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state; special cases spend their single cycle in FIXUP with the result already latched
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    core_step  = (state_q == ST_BUSY);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = special ? ST_FIXUP : ST_BUSY;
          core_start = !special;
        end
      end
      ST_BUSY:  if (core_last) state_d = ST_FIXUP;
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d    = ST_IDLE;
      core_start = 1'b0;
    end
  end

  // op, sign and result registers; the result only moves at acceptance or FIXUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MDU_MUL;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
    end else if (!flush) begin
      if ((state_q == ST_IDLE) && in_valid) begin
        op_q      <= in_op;
        neg_q     <= neg_d;
        special_q <= special;
        err_q     <= special && special_err;
        if (special) result_q <= special_result;
      end else if ((state_q == ST_FIXUP) && !special_q) begin
        result_q <= fixed_result;
      end
    end
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .step     (core_step),
    .mode_div (mdu_is_div(op_q)),
    .load_a   (mag_a),
    .load_b   (mag_b),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .last     (core_last)
  );

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit (expectations follow MDU_DIV_EN)
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  mdu_op_t         in_op = MDU_MUL;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_result;
  logic            out_err;

  int tests = 0;
  int fails = 0;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [0:13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // architectural reference: full-width products and truncating signed division
  task automatic ref_model(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic err, output int lat);
    logic [63:0] p;
    int sa, sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    err = 1'b0;
    lat = 33;
    res = '0;
    case (op)
      MDU_MUL:    begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; end
      MDU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; res = p[63:32]; end
      MDU_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; res = p[63:32]; end
      MDU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
      MDU_DIVU:   res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REMU:   res = (b == 0) ? a : a % b;
      MDU_DIV:    res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      MDU_REM:    res = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default:    res = '0;
    endcase
    if (mdu_is_div(op)) begin
      if (b == 0 || ((op == MDU_DIV || op == MDU_REM) && ovf)) lat = 1;
`ifndef MDU_DIV_EN
      res = '0;
      err = 1'b1;
      lat = 1;
`endif
    end
  endtask

  // present one op, wait for the result, optionally hold it under backpressure, then retire it
  task automatic do_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] res, output logic err, output int lat);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_op = mdu_op_t'($urandom_range(0, 7));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    err = out_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", out_result, res);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] r, er;
  logic        e, ee;
  int          l, el, n;
  bit          seen;
  mdu_op_t     rop;
  logic [31:0] ra, rb;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[4]  = '{MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[5]  = '{MDU_DIVU,   32'd100,        32'd7,         32'd14};
    vecs[6]  = '{MDU_REMU,   32'd100,        32'd7,         32'd2};
    vecs[7]  = '{MDU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[8]  = '{MDU_REM,    32'd5,          32'd0,         32'd5};
    vecs[9]  = '{MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{MDU_DIV,    32'd9,          32'd3,         32'd3};
    vecs[12] = '{MDU_MUL,    32'd3,          32'd3,         32'd9};
    vecs[13] = '{MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};

    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_result", out_result, 32'h0);
    check("reset_out_err", out_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed vectors; divide expectations collapse to err when the divider is absent
    for (int i = 0; i < 14; i++) begin
      ref_model(vecs[i].op, vecs[i].a, vecs[i].b, er, ee, el);
`ifdef MDU_DIV_EN
      er = vecs[i].res;
`else
      if (!mdu_is_div(vecs[i].op)) er = vecs[i].res;
`endif
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, e, l);
      check($sformatf("vec%0d_result", i), r, er);
      check($sformatf("vec%0d_err", i), e, ee);
      check($sformatf("vec%0d_latency", i), l, el);
    end

    // backpressure: result and in_ready held while out_ready stays low
    do_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2, 5, r, e, l);
    check("bp_result", r, 32'hFFFF_FFFF);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = mdu_op_t'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      ref_model(rop, ra, rb, er, ee, el);
      do_op(rop, ra, rb, 0, r, e, l);
      check($sformatf("rand%0d_%s_%h_%h", i, rop.name(), ra, rb), r, er);
      check($sformatf("rand%0d_err", i), e, ee);
      check($sformatf("rand%0d_latency", i), l, el);
    end

    // back-to-back throughput with out_ready held high
    @(negedge clk);
    out_ready = 1'b1;
    in_op = MDU_MULHU; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 100);
    check("throughput_gap", n + 1, XLEN + 3);
    in_op = MDU_MUL; in_a = 32'd1000; in_b = 32'd1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("throughput_second_result", out_result, 32'd1000000);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // flush during the iterations
    @(negedge clk);
    in_op = MDU_MUL; in_a = 32'd11; in_b = 32'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", seen, 1'b0);

    // asynchronous reset mid-operation after a nonzero result
    do_op(MDU_MUL, 32'd6, 32'd7, 0, r, e, l);
    check("pre_reset_result", r, 32'd42);
    @(negedge clk);
    in_op = MDU_MULHU; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(MDU_REMU, 32'd100, 32'd7, 0, r, e, l);
    ref_model(MDU_REMU, 32'd100, 32'd7, er, ee, el);
    check("post_reset_result", r, er);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
